// File: rtl/dsp_ccff_mode_loader.sv
// ---------------------------------------------------------------------------
// dsp_ccff_mode_loader
//   Loads the DSP tile's CHAIN_LEN-bit mode configuration chain (CCFF) from a
//   parallel word. One word is taken per cfg_valid/cfg_ready handshake and is
//   shifted MSB first into ccff_head with config_enable held high. The DSP
//   local reset is held asserted while the chain contents are changing.
//
//   Optional feature: define DSP_CCFF_VERIFY_EN to add a VERIFY pass that
//   recirculates the chain (ccff_head = ccff_tail) for CHAIN_LEN cycles and
//   compares every bit leaving ccff_tail against the captured word.
//
// Handshake: a word transfers on a rising prog_clock edge where
//   cfg_valid && cfg_ready && !abort. cfg_ready is high only in IDLE, does not
//   depend on cfg_valid, and cfg_valid may drop without a transfer. cfg_data is
//   sampled only on the transferring edge.
//
// Ports
//   prog_clock, prog_reset_n : configuration clock, async active-low reset
//   cfg_valid/cfg_ready/cfg_data : mode word input handshake
//   abort          : terminate the current load (ignored in IDLE)
//   config_enable  : CCFF shift enable to the DSP chain
//   ccff_head      : serial data into the chain
//   ccff_tail      : serial data out of the chain (used only by VERIFY)
//   dsp_lreset     : DSP local reset, high from accept until a load completes
//   busy           : high in any non-IDLE state
//   done           : one-cycle pulse when a load (and verify) completes
//   err            : sticky verify-mismatch / abort flag, cleared on accept
//   dbg_state      : current FSM state encoding
// ---------------------------------------------------------------------------
module dsp_ccff_mode_loader #(
  parameter int CHAIN_LEN = 84,
  parameter int CNT_W     = 7
) (
  input  logic                 prog_clock,
  input  logic                 prog_reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 abort,
  output logic                 config_enable,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 dsp_lreset,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);

`ifdef DSP_CCFF_VERIFY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_DONE   = 2'd3
  } state_e;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 cen_q, cen_d;
  logic                 head_q, head_d;
  logic                 lreset_q, lreset_d;
  logic                 err_q, err_d;

  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cen_q    <= 1'b0;
      head_q   <= 1'b0;
      lreset_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cen_q    <= cen_d;
      head_q   <= head_d;
      lreset_q <= lreset_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cen_d    = cen_q;
    head_d   = head_q;
    lreset_d = lreset_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        // abort wins over a coincident accept: the word is left on the bus.
        if (cfg_valid && !abort) begin
          state_d  = S_SHIFT;
          shadow_d = cfg_data;
          cnt_d    = '0;
          cen_d    = 1'b1;
          head_d   = cfg_data[CHAIN_LEN-1];
          lreset_d = 1'b1;
          err_d    = 1'b0;
        end
      end

      S_SHIFT: begin
        // head_q already carries shadow[LAST-cnt]; preload the next bit.
        if (cnt_q == LAST) begin
          head_d = 1'b0;
`ifdef DSP_CCFF_VERIFY_EN
          state_d = S_VERIFY;
          cnt_d   = '0;
`else
          state_d  = S_DONE;
          cen_d    = 1'b0;
          lreset_d = 1'b0;
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          head_d = shadow_q[LAST - CNT_W'(1) - cnt_q];
        end
      end

`ifdef DSP_CCFF_VERIFY_EN
      S_VERIFY: begin
        if (ccff_tail != shadow_q[LAST - cnt_q]) err_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          cen_d    = 1'b0;
          lreset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort leaves dsp_lreset as it is: the chain is only partially loaded.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cen_d   = 1'b0;
      head_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

`ifdef DSP_CCFF_VERIFY_EN
  // Recirculation during VERIFY restores the chain to its loaded contents.
  assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
`else
  logic unused_inputs;
  assign unused_inputs = ccff_tail ^ shadow_q[CHAIN_LEN-1];
  assign ccff_head     = head_q;
`endif

  assign cfg_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign config_enable = cen_q;
  assign dsp_lreset    = lreset_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule
